// File: rtl/conv_output_reader_pkg.sv
// Shared constants, stream indices and FSM encoding for the convolutional
// encoder output reader.
package conv_output_reader_pkg;

  localparam int unsigned K_SMALL  = 1056;
  localparam int unsigned K_LARGE  = 6144;
  localparam int unsigned NB_SMALL = K_SMALL / 8;  // 132 bytes per stream
  localparam int unsigned NB_LARGE = K_LARGE / 8;  // 768 bytes per stream
  localparam int unsigned NB_W     = 10;

  // Subblock stream indices
  localparam logic [1:0] D0 = 2'd0;
  localparam logic [1:0] D1 = 2'd1;
  localparam logic [1:0] D2 = 2'd2;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StCap,
    StOut
  } rd_state_e;

  // Bytes per stream for a given block size select
  function automatic logic [NB_W-1:0] nb_of(input logic size_sel);
    return size_sel ? NB_W'(NB_LARGE) : NB_W'(NB_SMALL);
  endfunction

  // One-hot read request for a stream index; zero for an illegal index
  function automatic logic [2:0] strm_onehot(input logic [1:0] strm);
    logic [2:0] oh;
    oh = 3'b000;
    unique case (strm)
      D0:      oh = 3'b001;
      D1:      oh = 3'b010;
      D2:      oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/conv_output_reader.sv
// Drains the three subblock FIFOs of one coded block into a single byte
// stream, interleaved d0,d1,d2 per byte, with valid/ready and sop/eop.
// One block is queued behind the active one; further requests set overflow.
module conv_output_reader
  import conv_output_reader_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         blk_done,
  input  logic         size_sel,
  input  logic [W-1:0] q0,
  input  logic [W-1:0] q1,
  input  logic [W-1:0] q2,
  input  logic [2:0]   fifo_empty,
  output logic [2:0]   rdreq_subblock,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_sop,
  output logic         out_eop,
  output logic         busy,
  output logic         overflow
);

  rd_state_e       state_q, state_d;
  logic [NB_W-1:0] nb_q, nb_d;
  logic [NB_W-1:0] byte_idx_q, byte_idx_d;
  logic [1:0]      strm_q, strm_d;
  logic            pend_q, pend_d;
  logic            pend_size_q, pend_size_d;
  logic            busy_q, busy_d;
  logic            ovf_q, ovf_d;
  logic [W-1:0]    out_data_q, out_data_d;
  logic            out_valid_q, out_valid_d;
  logic            out_sop_q, out_sop_d;
  logic            out_eop_q, out_eop_d;

  logic [W-1:0]    q_sel;
  logic            empty_sel;
  logic            last_byte;

  // Select the FIFO data and empty flag of the current stream
  always_comb begin
    q_sel     = '0;
    empty_sel = 1'b1;
    unique case (strm_q)
      D0: begin q_sel = q0; empty_sel = fifo_empty[0]; end
      D1: begin q_sel = q1; empty_sel = fifo_empty[1]; end
      D2: begin q_sel = q2; empty_sel = fifo_empty[2]; end
      default: begin q_sel = '0; empty_sel = 1'b1; end
    endcase
  end

  assign last_byte = (byte_idx_q == nb_q - NB_W'(1)) && (strm_q == D2);

  // Next-state, read request and output register logic
  always_comb begin
    state_d        = state_q;
    nb_d           = nb_q;
    byte_idx_d     = byte_idx_q;
    strm_d         = strm_q;
    pend_d         = pend_q;
    pend_size_d    = pend_size_q;
    busy_d         = busy_q;
    ovf_d          = ovf_q;
    out_data_d     = out_data_q;
    out_valid_d    = out_valid_q;
    out_sop_d      = out_sop_q;
    out_eop_d      = out_eop_q;
    rdreq_subblock = 3'b000;

    unique case (state_q)
      StIdle: begin
        if (blk_done || pend_q) begin
          // A queued block has priority; a simultaneous new pulse takes its slot
          nb_d        = pend_q ? nb_of(pend_size_q) : nb_of(size_sel);
          pend_d      = pend_q && blk_done;
          pend_size_d = (pend_q && blk_done) ? size_sel : pend_size_q;
          byte_idx_d  = '0;
          strm_d      = D0;
          busy_d      = 1'b1;
          state_d     = StReq;
        end
      end
      StReq: begin
        if (!empty_sel) begin
          rdreq_subblock = strm_onehot(strm_q);
          state_d        = StCap;
        end
      end
      StCap: begin
        // Non-show-ahead FIFO: data requested last cycle is on q now
        out_data_d  = q_sel;
        out_valid_d = 1'b1;
        out_sop_d   = (byte_idx_q == '0) && (strm_q == D0);
        out_eop_d   = last_byte;
        state_d     = StOut;
      end
      StOut: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          out_sop_d   = 1'b0;
          out_eop_d   = 1'b0;
          if (strm_q == D2) begin
            strm_d     = D0;
            byte_idx_d = byte_idx_q + NB_W'(1);
          end else begin
            strm_d = strm_q + 2'd1;
          end
          if (out_eop_q) begin
            busy_d  = 1'b0;
            state_d = StIdle;
          end else begin
            state_d = StReq;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // busy_q is still set on the eop-accept cycle, so a pulse there queues
    if (blk_done && busy_q) begin
      if (!pend_q) begin
        pend_d      = 1'b1;
        pend_size_d = size_sel;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      nb_q        <= '0;
      byte_idx_q  <= '0;
      strm_q      <= D0;
      pend_q      <= 1'b0;
      pend_size_q <= 1'b0;
      busy_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      nb_q        <= nb_d;
      byte_idx_q  <= byte_idx_d;
      strm_q      <= strm_d;
      pend_q      <= pend_d;
      pend_size_q <= pend_size_d;
      busy_q      <= busy_d;
      ovf_q       <= ovf_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_sop   = out_sop_q;
  assign out_eop   = out_eop_q;
  assign busy      = busy_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_conv_output_reader.sv
// Self-checking bench: FIFO model feeding the reader, a scoreboard of the
// expected interleaved stream, a vector table of full blocks and hand-written
// sequences for stall, queueing, overflow, reset and eop-coincident start.
module tb_conv_output_reader;

  logic       clk = 1'b0;
  logic       reset;
  logic       blk_done;
  logic       size_sel;
  logic [7:0] q0, q1, q2;
  logic [2:0] fifo_empty;
  logic [2:0] rdreq_subblock;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_sop;
  logic       out_eop;
  logic       busy;
  logic       overflow;

  always #5 clk = ~clk;

  conv_output_reader #(.W(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .blk_done       (blk_done),
    .size_sel       (size_sel),
    .q0             (q0),
    .q1             (q1),
    .q2             (q2),
    .fifo_empty     (fifo_empty),
    .rdreq_subblock (rdreq_subblock),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_sop        (out_sop),
    .out_eop        (out_eop),
    .busy           (busy),
    .overflow       (overflow)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       sop;
    logic       eop;
  } exp_t;

  typedef struct {
    logic size;
    bit   rnd;
    int   nb;
    int   total;
  } vec_t;

  // FIFO model state
  logic [7:0] qv [3];
  int         rp [3];
  int         wp;
  logic [2:0] force_e;

  assign q0 = qv[0];
  assign q1 = qv[1];
  assign q2 = qv[2];
  assign fifo_empty[0] = (rp[0] >= wp) || force_e[0];
  assign fifo_empty[1] = (rp[1] >= wp) || force_e[1];
  assign fifo_empty[2] = (rp[2] >= wp) || force_e[2];

  // Scoreboard and monitor state
  exp_t expq [$];
  int   eidx [3];
  int   n_chk, n_err;
  int   cyc, acc_cnt, sop_cnt, eop_cnt, byte_err, rd_bad, hold_err;
  int   rd_cnt [3];
  int   eop_cyc, gap;
  bit   had_eop, hold_prev, rnd_rdy, arm;
  logic [7:0] hold_d;
  logic hold_s, hold_e;

  function automatic logic [7:0] val(input int s, input int n);
    return 8'(s * 64 + n);
  endfunction

  task automatic check(input string name, input int got, input int want);
    n_chk++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  task automatic flush(input int words);
    for (int s = 0; s < 3; s++) begin
      rp[s] = 0; eidx[s] = 0; rd_cnt[s] = 0; qv[s] = 8'h00;
    end
    wp = words;
    expq.delete();
    acc_cnt = 0; sop_cnt = 0; eop_cnt = 0; byte_err = 0; rd_bad = 0; hold_err = 0;
    had_eop = 1'b0; hold_prev = 1'b0; gap = -1; eop_cyc = 0;
  endtask

  task automatic push_block(input int nb);
    exp_t e;
    for (int b = 0; b < nb; b++) begin
      for (int s = 0; s < 3; s++) begin
        e.data = val(s, eidx[s]);
        e.sop  = (b == 0) && (s == 0);
        e.eop  = (b == nb - 1) && (s == 2);
        eidx[s]++;
        expq.push_back(e);
      end
    end
  endtask

  // One clock: monitor at negedge, FIFO model and input drive after posedge
  task automatic tick();
    exp_t       e;
    logic [2:0] rd;
    @(negedge clk);
    cyc++;
    rd = rdreq_subblock;
    if (rd != 3'b000) begin
      if (($countones(rd) != 1) || ((rd & fifo_empty) != 3'b000)) rd_bad++;
    end
    for (int s = 0; s < 3; s++) if (rd[s] === 1'b1) rd_cnt[s]++;
    if (hold_prev && (!out_valid || out_data != hold_d || out_sop != hold_s ||
                      out_eop != hold_e)) hold_err++;
    hold_prev = out_valid && !out_ready;
    hold_d = out_data; hold_s = out_sop; hold_e = out_eop;
    if (out_valid && out_ready) begin
      acc_cnt++;
      if (out_sop) sop_cnt++;
      if (out_eop) eop_cnt++;
      if (out_sop && had_eop) gap = cyc - eop_cyc;
      if (out_eop) begin eop_cyc = cyc; had_eop = 1'b1; end
      if (expq.size() == 0) begin
        byte_err++;
      end else begin
        e = expq.pop_front();
        if (e.data != out_data || e.sop != out_sop || e.eop != out_eop) begin
          if (byte_err == 0)
            $display("  first bad byte #%0d: got %h sop%b eop%b, want %h sop%b eop%b",
                     acc_cnt, out_data, out_sop, out_eop, e.data, e.sop, e.eop);
          byte_err++;
        end
      end
      if (arm && out_eop) begin
        blk_done = 1'b1;
        size_sel = 1'b0;
        arm      = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    blk_done = 1'b0;
    for (int s = 0; s < 3; s++) begin
      if (rd[s] === 1'b1) begin
        qv[s] = val(s, rp[s]);
        rp[s]++;
      end
    end
    out_ready = rnd_rdy ? 1'($urandom_range(1, 0)) : 1'b1;
  endtask

  task automatic pulse(input logic sz);
    blk_done = 1'b1;
    size_sel = sz;
    tick();
  endtask

  task automatic wait_acc(input int n, input int budget);
    int i;
    i = 0;
    while (acc_cnt < n && i < budget) begin
      tick();
      i++;
    end
  endtask

  vec_t vecs [2];

  initial begin
    vecs[0] = '{size: 1'b0, rnd: 1'b0, nb: 132, total: 396};
    vecs[1] = '{size: 1'b1, rnd: 1'b1, nb: 768, total: 2304};

    n_chk = 0; n_err = 0; cyc = 0;
    reset = 1'b1; blk_done = 1'b0; size_sel = 1'b0; out_ready = 1'b1;
    force_e = 3'b000; rnd_rdy = 1'b0; arm = 1'b0;
    flush(0);
    repeat (3) tick();
    check("rst out_valid", int'(out_valid), 0);
    check("rst out_data", int'(out_data), 0);
    check("rst out_sop", int'(out_sop), 0);
    check("rst out_eop", int'(out_eop), 0);
    check("rst busy", int'(busy), 0);
    check("rst overflow", int'(overflow), 0);
    check("rst rdreq", int'(rdreq_subblock), 0);
    reset = 1'b0;
    tick();

    // Full blocks from the vector table
    for (int v = 0; v < 2; v++) begin
      flush(vecs[v].nb);
      push_block(vecs[v].nb);
      rnd_rdy = vecs[v].rnd;
      pulse(vecs[v].size);
      wait_acc(vecs[v].total, 30000);
      rnd_rdy = 1'b0;
      repeat (3) tick();
      check($sformatf("v%0d bytes", v), acc_cnt, vecs[v].total);
      check($sformatf("v%0d data", v), byte_err, 0);
      check($sformatf("v%0d sop count", v), sop_cnt, 1);
      check($sformatf("v%0d eop count", v), eop_cnt, 1);
      check($sformatf("v%0d busy after", v), int'(busy), 0);
      check($sformatf("v%0d rdreq d0", v), rd_cnt[0], vecs[v].nb);
      check($sformatf("v%0d rdreq d1", v), rd_cnt[1], vecs[v].nb);
      check($sformatf("v%0d rdreq d2", v), rd_cnt[2], vecs[v].nb);
      check($sformatf("v%0d rdreq legal", v), rd_bad, 0);
      check($sformatf("v%0d hold", v), hold_err, 0);
    end

    // d1 FIFO reports empty for 20 cycles once 10 bytes are out
    flush(132);
    push_block(132);
    pulse(1'b0);
    wait_acc(10, 200);
    force_e = 3'b010;
    repeat (20) tick();
    check("stall rdreq", int'(rdreq_subblock), 0);
    check("stall valid", int'(out_valid), 0);
    check("stall bytes", acc_cnt, 10);
    force_e = 3'b000;
    wait_acc(396, 3000);
    repeat (3) tick();
    check("stall total", acc_cnt, 396);
    check("stall data", byte_err, 0);
    check("stall rdreq legal", rd_bad, 0);

    // Two pulses while busy queue a block; a third sets overflow
    flush(264);
    push_block(132);
    push_block(132);
    pulse(1'b0);
    repeat (5) tick();
    pulse(1'b0);
    check("queue no overflow", int'(overflow), 0);
    pulse(1'b0);
    check("queue overflow", int'(overflow), 1);
    wait_acc(792, 6000);
    repeat (6) tick();
    check("queue bytes", acc_cnt, 792);
    check("queue data", byte_err, 0);
    check("queue sop count", sop_cnt, 2);
    check("queue eop count", eop_cnt, 2);
    check("queue restart gap", gap, 4);
    check("queue busy after", int'(busy), 0);
    check("overflow sticky", int'(overflow), 1);

    // Reset after 50 bytes abandons the block
    flush(132);
    push_block(132);
    pulse(1'b0);
    wait_acc(50, 400);
    reset = 1'b1;
    tick();
    check("mid rst out_valid", int'(out_valid), 0);
    check("mid rst out_data", int'(out_data), 0);
    check("mid rst out_sop", int'(out_sop), 0);
    check("mid rst out_eop", int'(out_eop), 0);
    check("mid rst busy", int'(busy), 0);
    check("mid rst overflow", int'(overflow), 0);
    check("mid rst rdreq", int'(rdreq_subblock), 0);
    reset = 1'b0;
    repeat (2) tick();
    check("idle rdreq", int'(rdreq_subblock), 0);
    flush(132);
    push_block(132);
    pulse(1'b0);
    wait_acc(396, 3000);
    repeat (3) tick();
    check("fresh bytes", acc_cnt, 396);
    check("fresh data", byte_err, 0);
    check("fresh sop count", sop_cnt, 1);

    // blk_done coincident with eop acceptance is queued, not lost
    flush(264);
    push_block(132);
    push_block(132);
    pulse(1'b0);
    arm = 1'b1;
    wait_acc(792, 6000);
    repeat (6) tick();
    check("coinc bytes", acc_cnt, 792);
    check("coinc data", byte_err, 0);
    check("coinc eop count", eop_cnt, 2);
    check("coinc restart gap", gap, 4);
    check("coinc overflow", int'(overflow), 0);
    check("coinc busy after", int'(busy), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
